// File: rtl/vector_top_pkg.sv
// -----------------------------------------------------------------------------
// vector_top_pkg
// Shared constants and types for the streaming vector datapath.
//   DW       element width
//   N        window length
//   SUM_W    width of the full-precision window sum (10 x 8-bit signed)
//   SAT_MAX  largest representable element value (+127)
//   SAT_MIN  smallest representable element value (-128)
// -----------------------------------------------------------------------------
package vector_top_pkg;

    localparam int DW    = 8;
    localparam int N     = 10;
    localparam int SUM_W = 12;

    typedef logic signed [DW-1:0] elem_t;

    localparam elem_t SAT_MAX = 8'sh7F;
    localparam elem_t SAT_MIN = 8'sh80;

endpackage

// File: rtl/vector_top_reduce_sat.sv
// -----------------------------------------------------------------------------
// vec_reduce_sat
// Combinational signed reduction of N window elements followed by saturation
// to the element range.
// Ports:
//   i_elem  N packed signed elements (index 0 = newest)
//   o_sum   saturated signed sum, DW bits
// -----------------------------------------------------------------------------
module vec_reduce_sat
    import vector_top_pkg::*;
(
    input  elem_t [N-1:0] i_elem,
    output elem_t         o_sum
);

    // Saturation bounds widened to the accumulator width (sign-extended).
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(SAT_MAX);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(SAT_MIN);

    logic signed [SUM_W-1:0] w_sum;

    function automatic elem_t sat_elem(input logic signed [SUM_W-1:0] s);
        if (s > SUM_MAX) begin
            return SAT_MAX;
        end else if (s < SUM_MIN) begin
            return SAT_MIN;
        end else begin
            return s[DW-1:0];
        end
    endfunction

    // 12 bits holds the worst case of 10 x (-128) = -1280 without overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = w_sum + {{(SUM_W-DW){i_elem[k][DW-1]}}, i_elem[k]};
        end
    end

    assign o_sum = sat_elem(w_sum);

endmodule

// File: rtl/vector_top.sv
// -----------------------------------------------------------------------------
// vector_top
// Streaming 8-bit vector datapath: a 10-deep shift window of the most recent
// samples and a registered signed saturating sum of that window.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset, clears window and f
//   next_in  signed sample consumed every cycle
//   r1..r10  window elements, r1 newest, r10 oldest
//   f        registered saturated sum of the window as it stood before the
//            last edge (sample-to-f latency of two edges)
// -----------------------------------------------------------------------------
module vector_top
    import vector_top_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] next_in,
    output logic [DW-1:0] r1,
    output logic [DW-1:0] r2,
    output logic [DW-1:0] r3,
    output logic [DW-1:0] r4,
    output logic [DW-1:0] r5,
    output logic [DW-1:0] r6,
    output logic [DW-1:0] r7,
    output logic [DW-1:0] r8,
    output logic [DW-1:0] r9,
    output logic [DW-1:0] r10,
    output logic [DW-1:0] f
);

    elem_t         r_win_p0 [N];
    elem_t         r_f_p1;
    elem_t [N-1:0] w_elem;
    elem_t         w_sat;

    always_comb begin
        w_elem = '0;
        for (int k = 0; k < N; k++) begin
            w_elem[k] = r_win_p0[k];
        end
    end

    vec_reduce_sat u_reduce (
        .i_elem (w_elem),
        .o_sum  (w_sat)
    );

    // Stage p0: sample window. Reset clears data too, so the zeros act as
    // padding for partially filled windows and X on next_in is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                r_win_p0[k] <= '0;
            end
        end else begin
            r_win_p0[0] <= elem_t'(next_in);
            for (int k = 1; k < N; k++) begin
                r_win_p0[k] <= r_win_p0[k-1];
            end
        end
    end

    // Stage p1: saturated reduction of the pre-shift window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_p1 <= '0;
        end else begin
            r_f_p1 <= w_sat;
        end
    end

    assign r1  = r_win_p0[0];
    assign r2  = r_win_p0[1];
    assign r3  = r_win_p0[2];
    assign r4  = r_win_p0[3];
    assign r5  = r_win_p0[4];
    assign r6  = r_win_p0[5];
    assign r7  = r_win_p0[6];
    assign r8  = r_win_p0[7];
    assign r9  = r_win_p0[8];
    assign r10 = r_win_p0[9];
    assign f   = r_f_p1;

endmodule

// File: tb/tb_vector_top.sv
module tb_vector_top;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] next_in;
    logic [7:0] r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, f;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference: list of samples received since the last reset (newest first,
    // at most 10 kept) and the expected f value.
    int hist[$];
    int exp_f;

    vector_top dut (
        .clk     (clk),
        .reset   (reset),
        .next_in (next_in),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .r4      (r4),
        .r5      (r5),
        .r6      (r6),
        .r7      (r7),
        .r8      (r8),
        .r9      (r9),
        .r10     (r10),
        .f       (f)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int clamp(input int s);
        if (s > 127)  return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    function automatic logic [7:0] exp_r(input int k);
        int v;
        v = (k < hist.size()) ? hist[k] : 0;
        return v[7:0];
    endfunction

    // One clock edge: drive inputs, advance the reference, then compare every
    // output one time unit after the edge.
    task automatic tick(input logic rst, input logic [7:0] din);
        int s;
        logic [7:0] got [10];
        reset   = rst;
        next_in = din;
        @(posedge clk);
        cyc++;
        if (rst) begin
            hist.delete();
            exp_f = 0;
        end else begin
            s = 0;
            foreach (hist[i]) s += hist[i];
            exp_f = clamp(s);
            hist.push_front(int'($signed(din)));
            if (hist.size() > 10) void'(hist.pop_back());
        end
        #1;
        got = '{r1, r2, r3, r4, r5, r6, r7, r8, r9, r10};
        for (int k = 0; k < 10; k++) chk($sformatf("r%0d", k + 1), got[k], exp_r(k));
        chk("f", f, exp_f[7:0]);
    endtask

    initial begin
        logic [7:0] mixed [10];
        mixed = '{8'h44, 8'h3F, 8'h36, 8'hB0, 8'h21, 8'hAE, 8'h8F, 8'hCF, 8'h62, 8'h84};
        reset   = 1'b1;
        next_in = 8'hxx;

        // Reset with X on the input
        tick(1'b1, 8'hxx);
        tick(1'b1, 8'hxx);
        chk("rst_f", f, 8'h00);
        chk("rst_r10", r10, 8'h00);
        for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
        chk("zero_f", f, 8'h00);

        // Shift and latency
        tick(1'b0, 8'h7F);
        chk("lat_r1_7F", r1, 8'h7F);
        tick(1'b0, 8'h04);
        chk("lat_f_7F", f, 8'h7F);
        tick(1'b0, 8'hF4);
        chk("lat_r3_7F", r3, 8'h7F);
        chk("lat_f_sat", f, 8'h7F);
        tick(1'b0, 8'hEC);
        chk("lat_f_77", f, 8'h77);

        // Window fill and eviction
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h01);
        tick(1'b0, 8'h00);
        chk("fill_f_0A", f, 8'h0A);
        chk("fill_r1", r1, 8'h00);
        chk("fill_r10", r10, 8'h01);
        tick(1'b0, 8'h00);
        chk("evict_f_09", f, 8'h09);

        // Negative saturation
        for (int i = 0; i < 13; i++) tick(1'b0, 8'h80);
        chk("neg_f_80", f, 8'h80);
        for (int i = 0; i < 11; i++) tick(1'b0, 8'hF0);
        chk("neg160_f", f, 8'h80);

        // Mixed sign windows
        for (int i = 0; i < 10; i++) tick(1'b0, mixed[i]);
        tick(1'b0, 8'h00);
        chk("mixed_f", f, 8'h80);
        for (int i = 0; i < 10; i++) tick(1'b0, (i % 2 == 0) ? 8'h01 : 8'hFF);
        tick(1'b0, 8'h00);
        chk("alt_f_00", f, 8'h00);

        // Random stream then a mid-stream reset
        for (int i = 0; i < 60; i++) tick(1'b0, 8'($urandom_range(0, 255)));
        tick(1'b1, 8'($urandom_range(0, 255)));
        chk("mid_rst_f", f, 8'h00);
        chk("mid_rst_r5", r5, 8'h00);
        tick(1'b0, 8'h05);
        tick(1'b0, 8'h00);
        chk("restart_f_05", f, 8'h05);

        // Longer random run with sparse resets and biased extremes
        for (int i = 0; i < 400; i++) begin
            logic [7:0] v;
            case ($urandom_range(0, 3))
                0:       v = 8'h7F - 8'($urandom_range(0, 3));
                1:       v = 8'h80 + 8'($urandom_range(0, 3));
                default: v = 8'($urandom_range(0, 255));
            endcase
            tick(($urandom_range(0, 49) == 0), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
